// File: rtl/ad_capture_module.sv
// ADC frame capture: detects ad_clk rising edges in the clk_20b domain and stores DEPTH samples
// into a read-first RAM. Optional rising-crossing trigger in ARM is enabled by defining AD_TRIG_EN.
module ad_capture_module #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk_20b,
  input  logic              rst_n,
  input  logic              ad_clk,
  input  logic [DATA_W-1:0] ad_data,
  input  logic              start,
  input  logic [DATA_W-1:0] trig_level,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_cnt,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_e;

  localparam int            MEM_N   = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_e              state_q, state_d;
  logic                ad_clk_d_q;
  logic                strobe;
  logic [DATA_W-1:0]   smp_q;
  logic                smp_vld_q;
  logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
  logic                busy_q, done_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                we;
  logic [ADDR_W-1:0]   wa;
  logic                start_acc;
  logic                trig_hit;
  logic [DATA_W-1:0]   mem_q [MEM_N];

  // ad_clk is already a clk_20b-registered level, so a plain edge detect suffices.
  assign strobe = ad_clk & ~ad_clk_d_q;

  always_ff @(posedge clk_20b or negedge rst_n) begin
    if (!rst_n) begin
      ad_clk_d_q <= 1'b0;
      smp_q      <= '0;
      smp_vld_q  <= 1'b0;
    end else begin
      ad_clk_d_q <= ad_clk;
      smp_vld_q  <= strobe;
      if (strobe) smp_q <= ad_data;
    end
  end

`ifdef AD_TRIG_EN
  logic [DATA_W-1:0] prev_smp_q, prev_smp_d;
  logic              prev_vld_q, prev_vld_d;

  // The first sample after arming only seeds prev_smp; a crossing needs a real predecessor.
  assign trig_hit = prev_vld_q && (prev_smp_q < trig_level) && (smp_q >= trig_level);

  always_comb begin
    prev_smp_d = prev_smp_q;
    prev_vld_d = prev_vld_q;
    if (start_acc) begin
      prev_vld_d = 1'b0;
    end else if (state_q == S_ARM && smp_vld_q && !trig_hit) begin
      prev_smp_d = smp_q;
      prev_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_20b or negedge rst_n) begin
    if (!rst_n) begin
      prev_smp_q <= '0;
      prev_vld_q <= 1'b0;
    end else begin
      prev_smp_q <= prev_smp_d;
      prev_vld_q <= prev_vld_d;
    end
  end
`else
  logic unused_trig;
  assign unused_trig = ^trig_level;
  assign trig_hit    = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    we        = 1'b0;
    wa        = wr_cnt_q[ADDR_W-1:0];
    start_acc = 1'b0;
    case (state_q)
      // A sample coinciding with the accepted start is dropped: no write happens here.
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_ARM;
          wr_cnt_d  = '0;
          start_acc = 1'b1;
        end
      end
      S_ARM: begin
        if (smp_vld_q && trig_hit) begin
          we       = 1'b1;
          wa       = '0;
          wr_cnt_d = (ADDR_W+1)'(1);
          state_d  = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (smp_vld_q) begin
          we       = 1'b1;
          wr_cnt_d = wr_cnt_q + (ADDR_W+1)'(1);
          if (wr_cnt_d == DEPTH_C) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_20b or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_cnt_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      busy_q   <= (state_d == S_ARM) || (state_d == S_CAPTURE);
      done_q   <= (state_d == S_DONE);
    end
  end

  always_ff @(posedge clk_20b) begin
    if (we) mem_q[wa] <= smp_q;
  end

  // Read-first: a same-cycle write to rd_addr is seen on the following read.
  always_ff @(posedge clk_20b or negedge rst_n) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= mem_q[rd_addr];
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_cnt    = wr_cnt_q;
  assign rd_data   = rd_data_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_ad_capture_module.sv
// Directed bench for ad_capture_module: capture frames, start/reset corner cases, fastest ad_clk,
// and (with AD_TRIG_EN) the rising-crossing trigger.
module tb_ad_capture_module;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1024;

  logic              clk_20b;
  logic              rst_n;
  logic              ad_clk;
  logic [DATA_W-1:0] ad_data;
  logic              start;
  logic [DATA_W-1:0] trig_level;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   wr_cnt;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        state_dbg;

  int n_checks;
  int n_errors;
  int done_rises;
  int rises_before;
  int cyc;

  ad_capture_module #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_20b   (clk_20b),
    .rst_n     (rst_n),
    .ad_clk    (ad_clk),
    .ad_data   (ad_data),
    .start     (start),
    .trig_level(trig_level),
    .busy      (busy),
    .done      (done),
    .wr_cnt    (wr_cnt),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk_20b = 1'b0;
  always #5 clk_20b = ~clk_20b;

  always @(posedge done) done_rises++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    start   = 1'b0;
    ad_clk  = 1'b0;
    ad_data = '0;
    rd_addr = '0;
    repeat (3) @(negedge clk_20b);
    rst_n = 1'b1;
    @(negedge clk_20b);
  endtask

  task automatic pulse_start();
    @(negedge clk_20b);
    ad_clk = 1'b0;
    start  = 1'b1;
    @(negedge clk_20b);
    start  = 1'b0;
  endtask

  // One ad_clk period of minimum length with a given data value; the write has landed on return.
  task automatic send_sample(input logic [DATA_W-1:0] val);
    @(negedge clk_20b);
    ad_clk  = 1'b1;
    ad_data = val;
    @(negedge clk_20b);
    ad_clk  = 1'b0;
    @(negedge clk_20b);
  endtask

  task automatic read_check(input int addr, input int exp, input string tag);
    @(negedge clk_20b);
    rd_addr = ADDR_W'(addr);
    @(negedge clk_20b);
    check(tag, 32'(rd_data), 32'(exp & ((1 << DATA_W) - 1)));
  endtask

  // Ramp generator: one value per ad_clk period; optional hook fires when wr_cnt hits hook_cnt
  // (act 1: pulse start, act 2: async reset mid-cycle with immediate checks).
  task automatic run_gen(input int period, input int base, input int budget, input bit stop_on_done,
                         input int hook_cnt, input int hook_act, output int cycles);
    int  ph;
    int  idx;
    bit  hooked;
    ph     = 0;
    idx    = 0;
    hooked = 1'b0;
    cycles = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_20b);
      start  = 1'b0;
      cycles = c;
      if (stop_on_done && done) break;
      if (!hooked && hook_act != 0 && int'(wr_cnt) == hook_cnt) begin
        hooked = 1'b1;
        if (hook_act == 1) begin
          start = 1'b1;
        end else begin
          #2 rst_n = 1'b0;
          #1;
          check("async_rst_busy", 32'(busy), 32'd0);
          check("async_rst_wr_cnt", 32'(wr_cnt), 32'd0);
          check("async_rst_done", 32'(done), 32'd0);
          break;
        end
      end
      if (ph == 0) begin
        ad_clk  = 1'b1;
        ad_data = DATA_W'(base + idx);
        idx++;
      end else if (ph == period / 2) begin
        ad_clk = 1'b0;
      end
      ph = (ph + 1) % period;
    end
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    done_rises = 0;
    trig_level = 12'h800;
    do_reset();

    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_wr_cnt", 32'(wr_cnt), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // Idle with ad_clk running: nothing is captured.
    run_gen(20, 5, 400, 1'b0, 0, 0, cyc);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_wr_cnt", 32'(wr_cnt), 32'd0);

`ifndef AD_TRIG_EN
    // start coinciding with smp_vld drops that sample.
    @(negedge clk_20b);
    ad_clk  = 1'b1;
    ad_data = 12'hABC;
    @(negedge clk_20b);
    ad_clk = 1'b0;
    start  = 1'b1;
    @(negedge clk_20b);
    start = 1'b0;
    check("coinc_busy", 32'(busy), 32'd1);
    check("coinc_wr_cnt0", 32'(wr_cnt), 32'd0);
    send_sample(12'h123);
    check("coinc_wr_cnt1", 32'(wr_cnt), 32'd1);
    read_check(0, 12'h123, "coinc_ram0");
    do_reset();

    // Full ramp frame, ad_clk period 4.
    rises_before = done_rises;
    pulse_start();
    check("f1_busy_armed", 32'(busy), 32'd1);
    run_gen(4, 0, 6000, 1'b1, 0, 0, cyc);
    check("f1_done", 32'(done), 32'd1);
    check("f1_busy", 32'(busy), 32'd0);
    check("f1_wr_cnt", 32'(wr_cnt), 32'(DEPTH));
    check("f1_done_rises", 32'(done_rises - rises_before), 32'd1);
    read_check(0, 0, "f1_ram0");
    read_check(1, 1, "f1_ram1");
    read_check(511, 511, "f1_ram511");
    read_check(1023, 1023, "f1_ram1023");

    // Strobes in DONE are ignored.
    run_gen(4, 3000, 40, 1'b0, 0, 0, cyc);
    check("f1_hold_wr_cnt", 32'(wr_cnt), 32'(DEPTH));
    check("f1_hold_done", 32'(done), 32'd1);
    read_check(0, 0, "f1_hold_ram0");
    read_check(1023, 1023, "f1_hold_ram1023");

    // Restart from DONE; start re-pulsed during CAPTURE at wr_cnt=300 is ignored.
    rises_before = done_rises;
    pulse_start();
    check("f2_done_clr", 32'(done), 32'd0);
    check("f2_busy", 32'(busy), 32'd1);
    check("f2_wr_cnt_clr", 32'(wr_cnt), 32'd0);
    run_gen(4, 2000, 6000, 1'b1, 300, 1, cyc);
    check("f2_done", 32'(done), 32'd1);
    check("f2_wr_cnt", 32'(wr_cnt), 32'(DEPTH));
    check("f2_done_rises", 32'(done_rises - rises_before), 32'd1);
    read_check(0, 2000, "f2_ram0");
    read_check(300, 2300, "f2_ram300");
    read_check(1023, 3023, "f2_ram1023");

    // Asynchronous reset mid-frame at wr_cnt=500.
    pulse_start();
    run_gen(4, 100, 4000, 1'b1, 500, 2, cyc);
    repeat (2) @(negedge clk_20b);
    ad_clk = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk_20b);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_done", 32'(done), 32'd0);

    // Fastest ad_clk: every address must hold the consecutive ramp value.
    pulse_start();
    run_gen(2, 12'h400, 4000, 1'b1, 0, 0, cyc);
    check("f3_done", 32'(done), 32'd1);
    check("f3_wr_cnt", 32'(wr_cnt), 32'(DEPTH));
    for (int k = 0; k < DEPTH; k++) begin
      read_check(k, 12'h400 + k, "f3_ram");
    end
`else
    // Rising crossing of 0x800 from below.
    pulse_start();
    send_sample(12'h100);
    send_sample(12'h400);
    send_sample(12'h7FF);
    check("tr1_wait_wr_cnt", 32'(wr_cnt), 32'd0);
    check("tr1_wait_busy", 32'(busy), 32'd1);
    send_sample(12'h900);
    check("tr1_wr_cnt", 32'(wr_cnt), 32'd1);
    send_sample(12'h950);
    check("tr1_wr_cnt2", 32'(wr_cnt), 32'd2);
    read_check(0, 12'h900, "tr1_ram0");
    read_check(1, 12'h950, "tr1_ram1");
    do_reset();

    // Starting above the threshold: wait for the next upward crossing.
    pulse_start();
    send_sample(12'hA00);
    send_sample(12'hB00);
    send_sample(12'h900);
    send_sample(12'h500);
    send_sample(12'h7F0);
    check("tr2_wait_wr_cnt", 32'(wr_cnt), 32'd0);
    send_sample(12'h800);
    check("tr2_wr_cnt", 32'(wr_cnt), 32'd1);
    read_check(0, 12'h800, "tr2_ram0");
    do_reset();
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ad_capture_module.md
Name: ad_capture_module

Overview:
- ADC sample-capture block on the receiving end of the ADC sample clock (ad_clk) that the design generates in the clk_20b (200 MHz) domain.
- Detects each ad_clk rising edge, latches the ADC parallel bus and writes a frame of DEPTH samples into an internal RAM.
- Downstream logic (FFT/measurement) starts a frame with a start pulse, waits for done, then reads samples back through a synchronous read port.

Parameters:
- DATA_W, 12, ADC data bus width.
- ADDR_W, 10, RAM address width.
- DEPTH, 1024, samples per frame; must be <= 2^ADDR_W and >= 2.

Ports:
- clk_20b  in  1  system clock, 200 MHz; sole clock of the block.
- rst_n  in  1  asynchronous active-low reset.
- ad_clk  in  1  ADC sample clock; a clk_20b-synchronous registered level.
- ad_data  in  DATA_W  ADC output bus, unsigned offset binary.
- start  in  1  one-cycle pulse that arms a new frame.
- trig_level  in  DATA_W  trigger threshold; used only with AD_TRIG_EN.
- busy  out  1  high while in ARM or CAPTURE.
- done  out  1  high from frame completion until the next accepted start.
- wr_cnt  out  ADDR_W+1  number of samples written in the current frame.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  RAM read data; 1-cycle latency.

Behaviour:
- Edge detect:
  - ad_clk_d <= ad_clk each cycle.
  - strobe = ad_clk & ~ad_clk_d.
  - No synchronizer is needed; the source is the same clock domain.
- Sample register: on a strobe cycle, smp <= ad_data and smp_vld <= 1 on the next cycle. smp_vld is otherwise 0.
- FSM, states IDLE, ARM, CAPTURE, DONE; reset state is IDLE.
  - IDLE --start--> ARM.
  - ARM --smp_vld and trigger condition--> CAPTURE. That qualifying sample is written at address 0 and wr_cnt becomes 1.
  - CAPTURE: each smp_vld writes smp at address wr_cnt, then wr_cnt increments. When the write makes wr_cnt == DEPTH, go to DONE.
  - DONE --start--> ARM, with wr_cnt cleared to 0 and done cleared on the same edge.
- Reset values: busy=0, done=0, wr_cnt=0, rd_data=0, ad_clk_d=0, smp=0, smp_vld=0. RAM contents are not reset.
- busy = (state==ARM || state==CAPTURE). done = (state==DONE). Both are registered state decodes.
- Start handling:
  - start while busy is ignored.
  - start in IDLE or DONE clears wr_cnt to 0 on the same edge.
  - If start and smp_vld coincide in IDLE/DONE, that sample is discarded. The first candidate sample is the next smp_vld.
- Write latency: ad_clk rising edge seen at fabric cycle t gives strobe at t+1, smp_vld at t+2, RAM write at t+2 edge.
- Throughput: at most one sample per 2 clk_20b cycles, because ad_clk needs a low phase. No backpressure exists; every strobe in CAPTURE is stored.
- ad_clk stopped: the FSM holds in ARM/CAPTURE indefinitely. There is no timeout.
- Overflow is impossible: writes stop exactly at DEPTH, and strobes in DONE/IDLE are ignored.
- Reads:
  - rd_data <= ram[rd_addr] every cycle, in any state.
  - A read of an address being written in the same cycle returns the old value (read-first).
  - Reads during CAPTURE are legal but return a partial frame.
- Reset asserted mid-frame: immediate return to IDLE, done=0, wr_cnt=0. Partial RAM data is retained but invalid.

Optional Feature:
- Macro AD_TRIG_EN.
- Defined: the ARM trigger condition is a rising crossing. Hold a register prev_smp of the last smp_vld sample taken in ARM; the condition is prev_smp < trig_level && smp >= trig_level. The first sample after entering ARM only loads prev_smp and cannot trigger.
- Undefined: the trigger condition is constant true, so capture begins at the first smp_vld after start. trig_level is unused and prev_smp is not built.

Test Plan:
- Reset then idle, ad_clk toggling every 10 cycles (N=20) → busy=0, done=0, wr_cnt=0, no RAM writes.
- start pulse, ad_data = ramp 0,1,2… incremented per ad_clk period, DEPTH=1024 → done after exactly 1024 samples; rd_addr k returns k one cycle later for k=0,1,511,1023.
- start asserted on the same cycle as smp_vld, ad_data=0xABC, then 0x123 → address 0 holds 0x123, not 0xABC.
- start re-pulsed during CAPTURE at wr_cnt=300 → ignored, frame completes at 1024 and done rises once. rst_n pulled low at wr_cnt=500 → busy=0, wr_cnt=0 immediately, asynchronously.
- Fastest ad_clk (period 2 cycles, N=2) → all 1024 consecutive ramp samples stored with no gaps.
- With AD_TRIG_EN, trig_level=0x800, sine input crossing 0x800 → ram[0] is the first sample >= 0x800 with its predecessor < 0x800. A sample sequence starting above 0x800 does not trigger until the next upward crossing.
